// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory access controller: state encoding,
// default geometry and a range helper.
package dm_pkg;

  // Default geometry of the data memory.
  localparam int unsigned MemSizeDef    = 9;
  localparam int unsigned AddrLengthDef = 11;
  localparam int unsigned DataLengthDef = 16;
  localparam int unsigned RdWaitDef     = 1;

  // Controller sequencing states.
  typedef enum logic [2:0] {
    StIdle,
    StWrSetup,
    StWrPulse,
    StWrHold,
    StRdWait,
    StRdRsp,
    StDumpRd,
    StDumpRsp
  } dm_state_e;

  // True when a (zero-extended) word address hits an implemented location.
  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned size);
    return addr < size;
  endfunction

endpackage

// File: rtl/dm_access_ctrl.sv
// Initiator side of the data-memory strobe interface. Sequences Addr/Data/Wr/Rd
// with fixed setup and hold around each access, returns read data on a
// valid/ready channel and can stream the whole memory out in address order.
module dm_access_ctrl
  import dm_pkg::*;
#(
  parameter int unsigned MEM_SIZE    = MemSizeDef,
  parameter int unsigned ADDR_LENGTH = AddrLengthDef,
  parameter int unsigned DATA_LENGTH = DataLengthDef,
  parameter int unsigned RD_WAIT     = RdWaitDef
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  input  logic                   i_req_we,
  input  logic [ADDR_LENGTH-1:0] i_req_addr,
  input  logic [DATA_LENGTH-1:0] i_req_wdata,
  input  logic                   i_dump_start,
  output logic                   o_rsp_valid,
  input  logic                   i_rsp_ready,
  output logic [DATA_LENGTH-1:0] o_rsp_rdata,
  output logic                   o_rsp_last,
  output logic                   o_err,
  output logic [ADDR_LENGTH-1:0] o_Addr,
  output logic [DATA_LENGTH-1:0] o_Data,
  output logic                   o_Wr,
  output logic                   o_Rd,
  input  logic [DATA_LENGTH-1:0] i_Data
);

  localparam int unsigned CntW = (RD_WAIT < 1) ? 1 : $clog2(RD_WAIT + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(RD_WAIT);
  localparam logic [ADDR_LENGTH-1:0] AddrLast = ADDR_LENGTH'(MEM_SIZE - 1);

  dm_state_e              state_q;
  logic                   req_ready_q;
  logic                   rsp_valid_q;
  logic [DATA_LENGTH-1:0] rsp_rdata_q;
  logic                   rsp_last_q;
  logic                   err_q;
  logic [ADDR_LENGTH-1:0] addr_q;
  logic [DATA_LENGTH-1:0] data_q;
  logic                   wr_q;
  logic                   rd_q;
  logic [CntW-1:0]        cnt_q;
  // Set for an out-of-range read: the read runs its normal timing without Rd
  // and answers with zero.
  logic                   oor_q;

  logic req_oor;
  logic req_fire;

  assign req_oor  = !addr_in_range(32'(i_req_addr), MEM_SIZE);
  assign req_fire = i_req_valid && req_ready_q;

  // Single sequencing FSM; every interface output is a register of this block.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_last_q  <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      cnt_q       <= '0;
      oor_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (i_dump_start) begin
            // Dump takes priority over a simultaneous request.
            state_q     <= StDumpRd;
            req_ready_q <= 1'b0;
            addr_q      <= '0;
            rd_q        <= 1'b1;
            cnt_q       <= CntLoad;
            oor_q       <= 1'b0;
          end else if (req_fire) begin
            addr_q <= i_req_addr;
            data_q <= i_req_wdata;
            err_q  <= req_oor;
            if (i_req_we) begin
              if (!req_oor) begin
                state_q     <= StWrSetup;
                req_ready_q <= 1'b0;
              end
            end else begin
              state_q     <= StRdWait;
              req_ready_q <= 1'b0;
              rd_q        <= !req_oor;
              oor_q       <= req_oor;
              cnt_q       <= CntLoad;
            end
          end else begin
            // Raises ready on the first edge after reset release.
            req_ready_q <= 1'b1;
          end
        end

        StWrSetup: begin
          state_q <= StWrPulse;
          wr_q    <= 1'b1;
        end

        StWrPulse: begin
          state_q <= StWrHold;
          wr_q    <= 1'b0;
        end

        StWrHold: begin
          state_q     <= StIdle;
          req_ready_q <= 1'b1;
        end

        StRdWait: begin
          if (cnt_q == '0) begin
            state_q     <= StRdRsp;
            rd_q        <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= oor_q ? '0 : i_Data;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end

        StRdRsp: begin
          if (i_rsp_ready) begin
            state_q     <= StIdle;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end

        StDumpRd: begin
          if (cnt_q == '0) begin
            state_q     <= StDumpRsp;
            rd_q        <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= i_Data;
            rsp_last_q  <= (addr_q == AddrLast);
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end

        StDumpRsp: begin
          if (i_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            if (rsp_last_q) begin
              // Counter stops at the last word rather than wrapping.
              state_q     <= StIdle;
              req_ready_q <= 1'b1;
            end else begin
              state_q <= StDumpRd;
              addr_q  <= addr_q + ADDR_LENGTH'(1);
              rd_q    <= 1'b1;
              cnt_q   <= CntLoad;
            end
          end
        end

        default: begin
          state_q     <= StIdle;
          req_ready_q <= 1'b1;
          wr_q        <= 1'b0;
          rd_q        <= 1'b0;
        end
      endcase
    end
  end

  assign o_req_ready = req_ready_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_last  = rsp_last_q;
  assign o_err       = err_q;
  assign o_Addr      = addr_q;
  assign o_Data      = data_q;
  assign o_Wr        = wr_q;
  assign o_Rd        = rd_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Self-checking bench for dm_access_ctrl: directed scenarios followed by random
// reads/writes checked against an abstract memory model.
module tb_dm_access_ctrl;

  localparam int MEM = 9;
  localparam int AW  = 11;
  localparam int DW  = 16;
  localparam int RW  = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          dump_start = 1'b0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_last;
  logic          err;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic          wr;
  logic          rd;
  logic [DW-1:0] mem_rdata;

  // Physical memory attached to the strobe interface.
  logic [DW-1:0] mem [0:15];
  // Abstract expectation of memory contents.
  logic [DW-1:0] ref_mem [0:15];
  int            wr_edges = 0;
  int            errors = 0;
  int            checks = 0;

  always #5 clk = ~clk;

  dm_access_ctrl #(
    .MEM_SIZE   (MEM),
    .ADDR_LENGTH(AW),
    .DATA_LENGTH(DW),
    .RD_WAIT    (RW)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_we    (req_we),
    .i_req_addr  (req_addr),
    .i_req_wdata (req_wdata),
    .i_dump_start(dump_start),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_rdata (rsp_rdata),
    .o_rsp_last  (rsp_last),
    .o_err       (err),
    .o_Addr      (addr),
    .o_Data      (data),
    .o_Wr        (wr),
    .o_Rd        (rd),
    .i_Data      (mem_rdata)
  );

  assign mem_rdata = (rd && (32'(addr) < MEM)) ? mem[addr[3:0]] : '0;

  always @(posedge wr) begin
    if (32'(addr) < MEM) mem[addr[3:0]] = data;
    wr_edges = wr_edges + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a request, wait for it to be taken; returns at the negedge after acceptance.
  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    for (int n = 0; n < 50 && !req_ready; n++) @(negedge clk);
    chk("req_ready_wait", 32'(req_ready), 1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int   e0;
    logic oor;
    e0  = wr_edges;
    oor = (32'(a) >= MEM);
    issue(1'b1, a, d);
    chk("wr_err", 32'(err), 32'(oor));
    if (!oor) begin
      chk("wr_setup_wr", 32'(wr), 0);
      chk("wr_setup_addr", 32'(addr), 32'(a));
      chk("wr_setup_data", 32'(data), 32'(d));
      @(negedge clk);
      chk("wr_pulse_wr", 32'(wr), 1);
      chk("wr_pulse_addr", 32'(addr), 32'(a));
      chk("wr_pulse_data", 32'(data), 32'(d));
      @(negedge clk);
      chk("wr_hold_wr", 32'(wr), 0);
      chk("wr_hold_addr", 32'(addr), 32'(a));
      chk("wr_hold_data", 32'(data), 32'(d));
      chk("wr_hold_ready", 32'(req_ready), 0);
      @(negedge clk);
      chk("wr_done_ready", 32'(req_ready), 1);
      ref_mem[a[3:0]] = d;
      chk("wr_mem", 32'(mem[a[3:0]]), 32'(d));
    end else begin
      for (int i = 0; i < 3; i++) begin
        chk("wr_oor_nowr", 32'(wr), 0);
        @(negedge clk);
      end
      chk("wr_oor_err_clear", 32'(err), 0);
    end
    chk("wr_edges", 32'(wr_edges - e0), oor ? 0 : 1);
    chk("wr_no_rsp", 32'(rsp_valid), 0);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int delay);
    logic          oor;
    logic [DW-1:0] exp;
    oor = (32'(a) >= MEM);
    exp = oor ? '0 : ref_mem[a[3:0]];
    issue(1'b0, a, '0);
    chk("rd_err", 32'(err), 32'(oor));
    if (!oor) begin
      for (int k = 0; k <= RW; k++) begin
        chk("rd_strobe", 32'(rd), 1);
        chk("rd_early_valid", 32'(rsp_valid), 0);
        @(negedge clk);
      end
      chk("rd_strobe_off", 32'(rd), 0);
    end else begin
      for (int n = 0; n < 20 && !rsp_valid; n++) begin
        chk("rd_oor_nord", 32'(rd), 0);
        @(negedge clk);
      end
    end
    chk("rd_valid", 32'(rsp_valid), 1);
    chk("rd_rdata", 32'(rsp_rdata), 32'(exp));
    chk("rd_last", 32'(rsp_last), 0);
    for (int i = 0; i < delay; i++) begin
      chk("rd_stall_ready", 32'(req_ready), 0);
      @(negedge clk);
      chk("rd_stall_valid", 32'(rsp_valid), 1);
      chk("rd_stall_rdata", 32'(rsp_rdata), 32'(exp));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rd_done_valid", 32'(rsp_valid), 0);
    chk("rd_done_ready", 32'(req_ready), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] ra;
    logic [DW-1:0] rdv;

    for (int i = 0; i < 16; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end

    // Reset state.
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_wr", 32'(wr), 0);
    chk("rst_rd", 32'(rd), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_addr", 32'(addr), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", 32'(req_ready), 1);

    // Directed scenarios.
    do_write(11'd3, 16'hBEEF);
    do_read(11'd3, 0);
    do_read(11'd9, 0);
    do_write(11'd12, 16'h5555);
    chk("oor_wr_mem3", 32'(mem[3]), 32'hBEEF);
    do_read(11'd3, 5);

    // Dump with a concurrent request that must wait for the dump to finish.
    for (int i = 0; i < MEM; i++) begin
      mem[i]     = DW'(i);
      ref_mem[i] = DW'(i);
    end
    rsp_ready  = 1'b1;
    dump_start = 1'b1;
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_addr   = 11'd5;
    @(negedge clk);
    dump_start = 1'b0;
    for (int w = 0; w < MEM; w++) begin
      for (int n = 0; n < 20 && !rsp_valid; n++) begin
        chk("dump_blocked", 32'(req_ready), 0);
        @(negedge clk);
      end
      chk("dump_valid", 32'(rsp_valid), 1);
      chk("dump_rdata", 32'(rsp_rdata), 32'(ref_mem[w]));
      chk("dump_last", 32'(rsp_last), (w == MEM - 1) ? 1 : 0);
      chk("dump_ready_low", 32'(req_ready), 0);
      @(negedge clk);
    end
    for (int n = 0; n < 20 && !req_ready; n++) @(negedge clk);
    chk("post_dump_ready", 32'(req_ready), 1);
    @(negedge clk);
    req_valid = 1'b0;
    for (int n = 0; n < 20 && !rsp_valid; n++) @(negedge clk);
    chk("post_dump_valid", 32'(rsp_valid), 1);
    chk("post_dump_rdata", 32'(rsp_rdata), 32'(ref_mem[5]));
    chk("post_dump_last", 32'(rsp_last), 0);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("post_dump_done", 32'(rsp_valid), 0);

    // Reset during the write pulse.
    issue(1'b1, 11'd4, 16'h1234);
    @(negedge clk);
    chk("rstw_pulse", 32'(wr), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstw_wr_drop", 32'(wr), 0);
    chk("rstw_ready", 32'(req_ready), 0);
    ref_mem[4] = 16'h1234;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rstw_rel_ready0", 32'(req_ready), 0);
    @(negedge clk);
    chk("rstw_rel_ready1", 32'(req_ready), 1);
    chk("rstw_valid", 32'(rsp_valid), 0);
    do_read(11'd4, 1);

    // Random traffic against the memory model.
    for (int t = 0; t < 40; t++) begin
      ra  = AW'($urandom_range(0, 15));
      rdv = DW'($urandom);
      if ($urandom_range(0, 1) == 1) do_write(ra, rdv);
      else do_read(ra, int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
